ntt_bram_arbiter: RTL and testbench

- Shares the single BRAM port (64-bit data, 10-bit byte address) between two requesters.
- Requester 0 is the NTT load/store sequencer; requester 1 is the host/debug access path.
- Round-robin arbitration, optional burst locking with a bounded burst length, and fixed-latency read-return routing back to the requester that issued each read.
- Sits between the NTT controller and BRAM port 0.

---
 rtl/ntt_bram_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ntt_bram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bram_arbiter.sv
// ntt_bram_arbiter: shares one BRAM port between the NTT sequencer (requester 0)
// and the host/debug path (requester 1). Round-robin arbitration, optional
// burst locking bounded by MAX_BURST, and fixed-latency read-return routing.
// Optional statistics counters are built when NTT_ARB_STATS_EN is defined.
module ntt_bram_arbiter #(
  parameter int DW        = 64,
  parameter int AW        = 8,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            we0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   wdata0,
  input  logic            lock0,
  input  logic            req1,
  input  logic            we1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata1,
  input  logic            lock1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic [DW-1:0]   rdata0,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata1,
`ifdef NTT_ARB_STATS_EN
  output logic [31:0]     stat_gnt0,
  output logic [31:0]     stat_gnt1,
  output logic [31:0]     stat_conflict,
`endif
  output logic [AW+1:0]   BRAM_addr,
  output logic [DW-1:0]   BRAM_din,
  input  logic [DW-1:0]   BRAM_dout,
  output logic            BRAM_en,
  output logic            BRAM_we,
  output logic            BRAM_clk
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic          bram_en_q, bram_en_d;
  logic          bram_we_q, bram_we_d;
  logic [AW+1:0] bram_addr_q, bram_addr_d;
  logic [DW-1:0] bram_din_q, bram_din_d;
  logic [RD_LAT:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT:0] tag_id_q, tag_id_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          acc, win, win_lock, win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          own_id, own_req, own_lock;
  logic [8:0]    cnt_inc;

  assign BRAM_clk  = clk;
  assign BRAM_en   = bram_en_q;
  assign BRAM_we   = bram_we_q;
  assign BRAM_addr = bram_addr_q;
  assign BRAM_din  = bram_din_q;

  // Grant decision: owner-only while locked, otherwise round-robin on contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        S_OWN0:  gnt0 = req0;
        S_OWN1:  gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign acc      = (req0 && gnt0) || (req1 && gnt1);
  assign win      = req1 && gnt1;
  assign win_lock = win ? lock1  : lock0;
  assign win_we   = win ? we1    : we0;
  assign win_addr = win ? addr1  : addr0;
  assign win_data = win ? wdata1 : wdata0;
  assign cnt_inc  = {1'b0, burst_cnt_q} + 9'd1;

  // Ownership FSM, last-winner tracking and burst length bound.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    own_id      = (state_q == S_OWN1);
    own_req     = own_id ? req1  : req0;
    own_lock    = own_id ? lock1 : lock0;
    if (acc) last_d = win;
    case (state_q)
      S_IDLE: begin
        // A single-beat burst limit means a lock can never extend ownership.
        if (acc && win_lock && (MAX_BURST > 1)) begin
          state_d     = win ? S_OWN1 : S_OWN0;
          burst_cnt_d = 8'd1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (acc) begin
          burst_cnt_d = cnt_inc[7:0];
          if (!win_lock || (cnt_inc >= 9'(MAX_BURST))) state_d = S_IDLE;
        end else if (!own_req && !own_lock) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next BRAM command; address/data hold their last value when idle.
  always_comb begin
    bram_en_d   = acc;
    bram_we_d   = acc && win_we;
    bram_addr_d = acc ? {win_addr, 2'b00} : bram_addr_q;
    bram_din_d  = acc ? win_data : bram_din_q;
  end

  // Read tag pipe: stage k is valid RD_LAT-k cycles before its data arrives.
  always_comb begin
    tag_vld_d = {tag_vld_q[RD_LAT-1:0], acc && !win_we};
    tag_id_d  = {tag_id_q[RD_LAT-1:0], win};
  end

  assign rvalid0 = tag_vld_q[RD_LAT] && !tag_id_q[RD_LAT] && !rst;
  assign rvalid1 = tag_vld_q[RD_LAT] &&  tag_id_q[RD_LAT] && !rst;
  assign rdata0  = rvalid0 ? BRAM_dout : rdata0_q;
  assign rdata1  = rvalid1 ? BRAM_dout : rdata1_q;

  // Read-data hold registers keep the last returned word per requester.
  always_comb begin
    rdata0_d = rdata0;
    rdata1_d = rdata1;
  end

  // State and output registers; reset releases ownership and drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

`ifdef NTT_ARB_STATS_EN
  logic [31:0] stat_gnt0_q, stat_gnt0_d;
  logic [31:0] stat_gnt1_q, stat_gnt1_d;
  logic [31:0] stat_conflict_q, stat_conflict_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    sat_inc = (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  assign stat_gnt0     = stat_gnt0_q;
  assign stat_gnt1     = stat_gnt1_q;
  assign stat_conflict = stat_conflict_q;

  // Saturating accept and contention counters.
  always_comb begin
    stat_gnt0_d     = sat_inc(stat_gnt0_q, req0 && gnt0);
    stat_gnt1_d     = sat_inc(stat_gnt1_q, req1 && gnt1);
    stat_conflict_d = sat_inc(stat_conflict_q, req0 && req1 && (gnt0 != gnt1));
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0_q     <= '0;
      stat_gnt1_q     <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_gnt0_q     <= stat_gnt0_d;
      stat_gnt1_q     <= stat_gnt1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// Testbench for ntt_bram_arbiter: directed scenarios plus random traffic,
// checked by a scoreboard fed from a transaction-level reference model.
module tb_ntt_bram_arbiter;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int RD_LAT = 2;
  localparam int MB = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, BRAM_en, BRAM_we, BRAM_clk;
  logic [DW-1:0] rdata0, rdata1, BRAM_din, BRAM_dout;
  logic [AW+1:0] BRAM_addr;
`ifdef NTT_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  ntt_bram_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef NTT_ARB_STATS_EN
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict),
`endif
    .BRAM_addr(BRAM_addr), .BRAM_din(BRAM_din), .BRAM_dout(BRAM_dout),
    .BRAM_en(BRAM_en), .BRAM_we(BRAM_we), .BRAM_clk(BRAM_clk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= rst;

  // BRAM behavioural model: RD_LAT-cycle registered read, preloaded with 100+i.
  logic [DW-1:0] bram_mem [256];
  logic [DW-1:0] rdp [RD_LAT];
  bit preloaded = 0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) bram_mem[i] <= 64'(100 + i);
      preloaded <= 1;
    end else if (BRAM_en && BRAM_we) begin
      bram_mem[BRAM_addr[AW+1:2]] <= BRAM_din;
    end
    rdp[0] <= bram_mem[BRAM_addr[AW+1:2]];
    for (int k = 1; k < RD_LAT; k++) rdp[k] <= rdp[k-1];
  end
  assign BRAM_dout = rdp[RD_LAT-1];

  typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;
  typedef struct { int due; bit en; bit we; bit zero; logic [AW+1:0] addr; logic [DW-1:0] din; } bus_t;
  rd_t  rd_q[$];
  bus_t bus_q[$];
  int wins[$];

  int checks = 0;
  int errs = 0;
  bit mon_en = 0;

  // Reference model state: owner -1 = nobody holds a lock.
  logic [DW-1:0] ref_mem [256];
  int owner = -1;
  int last_w = 1;
  int bcnt = 0;

  task automatic step(input logic r0, input logic w0, input logic l0, input int a0,
                      input logic [DW-1:0] d0, input logic r1, input logic w1,
                      input logic l1, input int a1, input logic [DW-1:0] d1, input logic rs);
    int exp_g, act;
    logic rq[2], wq[2], lk[2];
    int ad[2];
    logic [DW-1:0] dd[2];
    bus_t b;
    rd_t r;
    @(posedge clk); #1;
    rst = rs; req0 = r0; we0 = w0; lock0 = l0; addr0 = AW'(a0); wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = AW'(a1); wdata1 = d1;
    #1;
    rq[0] = r0; rq[1] = r1; wq[0] = w0; wq[1] = w1; lk[0] = l0; lk[1] = l1;
    ad[0] = a0; ad[1] = a1; dd[0] = d0; dd[1] = d1;
    if (rs) exp_g = -1;
    else if (owner >= 0) exp_g = rq[owner] ? owner : -1;
    else if (r0 && r1) exp_g = 1 - last_w;
    else exp_g = r0 ? 0 : (r1 ? 1 : -1);
    act = gnt0 ? (gnt1 ? 2 : 0) : (gnt1 ? 1 : -1);
    checks++;
    if (act != exp_g) begin
      errs++;
      $display("FAIL grant cyc=%0d: got %0d want %0d", cyc, act, exp_g);
    end
    wins.push_back(act);
    b.due = cyc + 1; b.zero = rs; b.en = 0; b.we = 0; b.addr = '0; b.din = '0;
    if (rs) begin
      rd_q.delete();
      owner = -1; last_w = 1; bcnt = 0;
    end else if (exp_g >= 0) begin
      b.en = 1; b.we = wq[exp_g];
      b.addr = (AW+2)'(ad[exp_g]) << 2; b.din = dd[exp_g];
      if (wq[exp_g]) ref_mem[ad[exp_g]] = dd[exp_g];
      else begin
        r.due = cyc + 1 + RD_LAT; r.id = exp_g; r.data = ref_mem[ad[exp_g]];
        rd_q.push_back(r);
      end
      last_w = exp_g;
      if (owner < 0) begin
        if (lk[exp_g] && MB > 1) begin owner = exp_g; bcnt = 1; end
      end else begin
        bcnt++;
        if (!lk[exp_g] || bcnt >= MB) owner = -1;
      end
    end else if (owner >= 0 && !rq[owner] && !lk[owner]) begin
      owner = -1;
    end
    bus_q.push_back(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0,'0, 0,0,0,0,'0, 0);
  endtask

  task automatic chk_wins(input string name, input int exp[$]);
    checks++;
    if (wins != exp) begin
      errs++;
      $display("FAIL %s: got %p want %p", name, wins, exp);
    end
  endtask

  // Monitor: compares BRAM command bus, read returns and held read data.
  logic [DW-1:0] hold0 = '0, hold1 = '0;
  always @(negedge clk) begin
    bus_t b;
    rd_t r;
    logic [DW-1:0] got;
    if (mon_en) begin
      if (rst_seen) begin hold0 = '0; hold1 = '0; end
      while (bus_q.size() > 0 && bus_q[0].due < cyc) void'(bus_q.pop_front());
      if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
        b = bus_q.pop_front();
        checks++;
        if (BRAM_en !== b.en || BRAM_we !== b.we ||
            ((b.en || b.zero) && (BRAM_addr !== b.addr || BRAM_din !== b.din))) begin
          errs++;
          $display("FAIL bram_bus cyc=%0d: got en=%b we=%b addr=%0d din=%0h want en=%b we=%b addr=%0d din=%0h",
                   cyc, BRAM_en, BRAM_we, BRAM_addr, BRAM_din, b.en, b.we, b.addr, b.din);
        end
      end
      if (rvalid0 || rvalid1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errs++;
          $display("FAIL rvalid_unexpected cyc=%0d: got rvalid0=%b rvalid1=%b want none", cyc, rvalid0, rvalid1);
        end else begin
          r = rd_q.pop_front();
          got = rvalid1 ? rdata1 : rdata0;
          if (r.due != cyc || (rvalid0 && rvalid1) || r.id != (rvalid1 ? 1 : 0) || got !== r.data) begin
            errs++;
            $display("FAIL read_return cyc=%0d: got rv0=%b rv1=%b data=%0h want id=%0d due=%0d data=%0h",
                     cyc, rvalid0, rvalid1, got, r.id, r.due, r.data);
          end
          if (r.id == 0) hold0 = r.data; else hold1 = r.data;
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r = rd_q.pop_front();
        checks++; errs++;
        $display("FAIL read_missing cyc=%0d: got no rvalid want id=%0d data=%0h", cyc, r.id, r.data);
      end
      checks++;
      if ((!rvalid0 && rdata0 !== hold0) || (!rvalid1 && rdata1 !== hold1)) begin
        errs++;
        $display("FAIL rdata_hold cyc=%0d: got %0h/%0h want %0h/%0h", cyc, rdata0, rdata1, hold0, hold1);
      end
    end
  end

  initial begin
    int e[$];
    logic r0, r1, w0, w1, l0, l1, rs;
    for (int i = 0; i < 256; i++) ref_mem[i] = 64'(100 + i);
    step(0,0,0,0,'0, 0,0,0,0,'0, 1);
    mon_en = 1;
    step(0,0,0,0,'0, 0,0,0,0,'0, 1);
    idle(2);

    // Contention right after reset: strict alternation starting with requester 0.
    wins.delete();
    for (int i = 0; i < 4; i++) step(1,0,0,40+i,'0, 1,0,0,50+i,'0, 0);
    e = '{0,1,0,1}; chk_wins("contention", e);
    idle(4);

    // Locked burst of 10 writes by requester 0 while requester 1 waits.
    wins.delete();
    for (int i = 0; i < 10; i++) step(1,1,(i < 9),200+i,64'(1000+i), 1,0,0,30,'0, 0);
    step(0,0,0,0,'0, 1,0,0,31,'0, 0);
    e = '{0,0,0,0,0,0,0,0,0,0,1}; chk_wins("locked_burst", e);
    idle(4);

    // Continuous lock: forced release after MB grants, one grant to 1, then 0 again.
    wins.delete();
    for (int i = 0; i < MB + 2; i++) step(1,1,1,150+i,64'(2000+i), 1,0,0,32,'0, 0);
    e.delete();
    for (int i = 0; i < MB; i++) e.push_back(0);
    e.push_back(1); e.push_back(0);
    chk_wins("forced_release", e);
    wins.delete();
    step(0,0,0,0,'0, 1,0,0,33,'0, 0);
    e = '{-1}; chk_wins("owner_idle_hold", e);
    step(0,0,0,0,'0, 0,0,0,0,'0, 0);
    idle(4);

    // Back-to-back reads by requester 1 of words 0..7.
    for (int i = 0; i < 8; i++) step(0,0,0,0,'0, 1,0,0,i,'0, 0);
    idle(6);

    // Write 0xA5 to word 5, then a single read of it by requester 0.
    step(1,1,0,5,64'hA5, 0,0,0,0,'0, 0);
    step(1,0,0,5,'0, 0,0,0,0,'0, 0);
    idle(6);

    // Reset the cycle after a read accept; the read must never return.
    step(1,0,0,3,'0, 0,0,0,0,'0, 0);
    step(0,0,0,0,'0, 0,0,0,0,'0, 1);
    idle(5);
    wins.delete();
    step(1,0,0,7,'0, 1,0,0,8,'0, 0);
    e = '{0}; chk_wins("post_reset_contention", e);
    idle(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r0 = ($urandom_range(0,99) < 60); r1 = ($urandom_range(0,99) < 60);
      w0 = $urandom_range(0,1); w1 = $urandom_range(0,1);
      l0 = ($urandom_range(0,99) < 35); l1 = ($urandom_range(0,99) < 35);
      rs = ($urandom_range(0,299) == 0);
      step(r0,w0,l0,$urandom_range(0,15),{$urandom(),$urandom()},
           r1,w1,l1,$urandom_range(0,15),{$urandom(),$urandom()}, rs);
    end
    idle(RD_LAT + 6);

    checks++;
    if (rd_q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d outstanding reads want 0", rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
